// File: rtl/req_enc_pkg.sv
// Shared definitions for the request encoder: default sizes, FSM state type
// and the one-hot helper used to retire a selected request.
package req_enc_pkg;

  localparam int DEF_N_REQ = 16;
  localparam int DEF_IDX_W = $clog2(DEF_N_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [DEF_N_REQ-1:0] onehot(input logic [DEF_IDX_W-1:0] idx);
    return DEF_N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/prio_enc16.sv
// Combinational priority encoder: lowest set bit at or after 'start', wrapping.
// With start tied to 0 this is a plain lowest-index-wins encoder.
module prio_enc16 #(
  parameter int N_REQ = 16,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  localparam logic [2*N_REQ-1:0] ONE = (2*N_REQ)'(1);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] keep;
  logic [2*N_REQ-1:0] masked;

  // Upper copy supplies the wrapped-around candidates below 'start'.
  assign dbl    = {vec, vec};
  assign keep   = ~((ONE << start) - ONE);
  assign masked = dbl & keep;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 2*N_REQ-1; i >= 0; i--) begin
      if (masked[i]) begin
        idx   = IDX_W'(i % N_REQ);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_encoder16.sv
// Collects request pulses into a pending set and presents one index per
// valid/ready handshake. Define REQ_ENCODER_RR_EN for round-robin selection.
module req_encoder16
  import req_enc_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_REQ-1:0] pending,
  output logic             ovf,
  input  logic             ovf_clr
);

  state_t             state;
  state_t             state_nxt;
  logic [N_REQ-1:0]   pending_q;
  logic [N_REQ-1:0]   cand;
  logic [N_REQ-1:0]   sel_oh;
  logic [DEF_N_REQ-1:0] sel_oh_full;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   start;
  logic [IDX_W-1:0]   idx_q;
  logic               found;
  logic               free;
  logic               load;
  logic               lost;
  logic               ovf_q;

  assign cand = pending_q | req_in;
  // Accept and reload share one edge, so a held index never costs a bubble.
  assign free = (state == IDLE) || out_ready;
  assign load = free && found;

`ifdef REQ_ENCODER_RR_EN
  logic [IDX_W-1:0] last_q;

  assign start = last_q + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_q <= '0;
    else if (load) last_q <= sel;
  end
`else
  assign start = '0;
`endif

  prio_enc16 #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_prio (
    .vec  (cand),
    .start(start),
    .idx  (sel),
    .found(found)
  );

  assign sel_oh_full = onehot(DEF_IDX_W'(sel));
  assign sel_oh      = load ? sel_oh_full[N_REQ-1:0] : '0;
  // A repeat request for a bit that stays pending collapses into one entry.
  assign lost        = |(req_in & pending_q & ~sel_oh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load)      state_nxt = HOLD;
    else if (free) state_nxt = IDLE;
  end

  always_comb begin
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      pending_q <= '0;
    end else if (load) begin
      idx_q     <= sel;
      pending_q <= cand & ~sel_oh;
    end else if (!free) begin
      pending_q <= cand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf_q <= 1'b0;
    else if (lost)    ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end

  assign out_idx = idx_q;
  assign pending = pending_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_req_encoder16.sv
// Randomized + directed bench: a set-based reference model pushes expected
// indices into a queue, a negedge monitor pops them on each handshake.
module tb_req_encoder16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req_in = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic [15:0] pending;
  logic        ovf;
  logic        ovf_clr = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  int        exp_q[$];
  int        m_held;
  int        m_idx;
  int        m_last;
  bit [15:0] m_pend;
  bit        m_ovf;

  always #5 clk = ~clk;

  req_encoder16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_idx  (out_idx),
    .pending  (pending),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = -1;
    m_idx  = 0;
    m_last = 0;
    m_pend = '0;
    m_ovf  = 1'b0;
    exp_q.delete();
  endtask

  // Reference: sets of outstanding requests, one held index, search by scanning.
  task automatic model_step(input bit [15:0] req, input bit rdy, input bit clr);
    bit [15:0] c;
    bit        free;
    bit        lost;
    int        s;
    int        st;
    c    = m_pend | req;
    free = (m_held < 0) || rdy;
    s    = -1;
    st   = 0;
`ifdef REQ_ENCODER_RR_EN
    st = (m_last + 1) % 16;
`endif
    if (free) begin
      for (int j = 0; j < 16; j++) begin
        if (s < 0 && c[(st + j) % 16]) s = (st + j) % 16;
      end
    end
    lost = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (req[k] && m_pend[k] && k != s) lost = 1'b1;
    end
    if (free) begin
      if (s >= 0) begin
        m_held = s;
        m_idx  = s;
        m_last = s;
        c[s]   = 1'b0;
        m_pend = c;
        exp_q.push_back(s);
      end else begin
        m_held = -1;
      end
    end else begin
      m_pend = c;
    end
    if (lost)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid"}, int'(out_valid), int'(m_held >= 0));
    check({tag, ".idx"}, int'(out_idx), m_idx);
    check({tag, ".pending"}, int'(pending), int'(m_pend));
    check({tag, ".ovf"}, int'(ovf), int'(m_ovf));
  endtask

  // Called at posedge+1; drives inputs, advances the model across one edge.
  task automatic cycle(input bit [15:0] req, input bit rdy, input bit clr, input string tag);
    req_in    = req;
    out_ready = rdy;
    ovf_clr   = clr;
    model_step(req, rdy, clr);
    @(posedge clk);
    #1;
    req_in    = '0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    check_state(tag);
  endtask

  // Monitor: each handshake seen before its accepting edge pops one expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("mon.unexpected", int'(out_idx), -1);
      end else begin
        check("mon.idx", int'(out_idx), exp_q.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    #3;
    check_state("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset while holding: output drops immediately, nothing follows.
    cycle(16'h0008, 1'b0, 1'b0, "rst_hold");
    cycle(16'h0008, 1'b0, 1'b0, "rst_hold2");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle(16'h0000, 1'b1, 1'b0, "post_rst");

    // Fixed priority burst.
    cycle(16'h8421, 1'b1, 1'b0, "prio0");
    for (int i = 0; i < 5; i++) cycle(16'h0000, 1'b1, 1'b0, "prio");

    // Backpressure with a repeat of the held index.
    cycle(16'h0010, 1'b0, 1'b0, "bp_load");
    for (int i = 0; i < 4; i++) cycle(16'h0000, 1'b0, 1'b0, "bp_hold");
    cycle(16'h0010, 1'b0, 1'b0, "bp_again");
    for (int i = 0; i < 3; i++) cycle(16'h0000, 1'b1, 1'b0, "bp_drain");

    // Overflow set, clear collision, clear.
    cycle(16'h0001, 1'b0, 1'b0, "ovf_load");
    cycle(16'h0002, 1'b0, 1'b0, "ovf_p1");
    cycle(16'h0002, 1'b0, 1'b0, "ovf_p2");
    cycle(16'h0002, 1'b0, 1'b1, "ovf_clr_collide");
    cycle(16'h0000, 1'b0, 1'b1, "ovf_clr");
    for (int i = 0; i < 3; i++) cycle(16'h0000, 1'b1, 1'b0, "ovf_drain");

    // Accept and new request at the same edge.
    cycle(16'h0001, 1'b0, 1'b0, "b2b_load");
    cycle(16'h0001, 1'b1, 1'b0, "b2b_reload");
    cycle(16'h0000, 1'b1, 1'b0, "b2b_drain");
    cycle(16'h0000, 1'b1, 1'b0, "b2b_idle");

    // Random traffic: sparse requests, random backpressure, occasional clear.
    for (int i = 0; i < 400; i++) begin
      cycle(16'($urandom & $urandom & $urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 7) == 0), "rand");
    end
    for (int i = 0; i < 24; i++) cycle(16'h0000, 1'b1, 1'b0, "final_drain");
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
